// File: rtl/timer_digit_decoder.sv
// rtl/timer_digit_decoder.sv - countdown value to BCD digits with time-up pulse and low-time blink
module timer_digit_decoder #(
  parameter int VALUE_WIDTH        = 32,
  parameter int CONV_BITS          = 10,
  parameter int LOW_TIME_THRESHOLD = 10,
  parameter int BLINK_TICKS        = 12_500_000
) (
  input  logic                          vga_clock,
  input  logic                          reset,
  input  logic signed [VALUE_WIDTH-1:0] seconds_count,
  output logic        [3:0]             digit_hundreds,
  output logic        [3:0]             digit_tens,
  output logic        [3:0]             digit_ones,
  output logic                          digits_valid,
  output logic                          digits_update,
  output logic                          time_up,
  output logic                          blink_visible
);

  localparam int BCD_W   = 12;
  localparam int CNT_W   = $clog2(CONV_BITS + 1);
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic signed [VALUE_WIDTH-1:0] MAX_VALUE = VALUE_WIDTH'(999);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                          state;
  logic                            force_conv;
  logic signed [VALUE_WIDTH-1:0]   sample_q;
  logic        [CONV_BITS-1:0]     clamped;
  logic        [CONV_BITS-1:0]     bin_q;
  logic        [CONV_BITS-1:0]     conv_q;
  logic        [CONV_BITS-1:0]     last_converted;
  logic        [BCD_W-1:0]         bcd_q;
  logic        [BCD_W-1:0]         bcd_adj;
  logic        [BCD_W+CONV_BITS-1:0] dabble_next;
  logic        [CNT_W-1:0]         bit_cnt;
  logic        [BLINK_W-1:0]       blink_cnt;
  logic                            blink_active;

  always_comb begin
    clamped = '0;
    if (sample_q < 0)
      clamped = '0;
    else if (sample_q > MAX_VALUE)
      clamped = CONV_BITS'(999);
    else
      clamped = sample_q[CONV_BITS-1:0];
  end

  // Add-3 correction on every nibble before the shift keeps each digit decimal.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
    dabble_next = {bcd_adj, bin_q} << 1;
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      force_conv     <= 1'b1;
      sample_q       <= '0;
      bin_q          <= '0;
      conv_q         <= '0;
      bcd_q          <= '0;
      bit_cnt        <= '0;
      last_converted <= '0;
      digit_hundreds <= '0;
      digit_tens     <= '0;
      digit_ones     <= '0;
      digits_valid   <= 1'b0;
      digits_update  <= 1'b0;
      time_up        <= 1'b0;
    end else begin
      sample_q      <= seconds_count;
      digits_update <= 1'b0;
      time_up       <= 1'b0;
      case (state)
        IDLE: begin
          if (force_conv || (clamped != last_converted)) begin
            force_conv <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          bin_q   <= clamped;
          conv_q  <= clamped;
          bcd_q   <= '0;
          bit_cnt <= CNT_W'(CONV_BITS);
          state   <= SHIFT;
        end
        SHIFT: begin
          {bcd_q, bin_q} <= dabble_next;
          bit_cnt        <= bit_cnt - 1'b1;
          if (bit_cnt == CNT_W'(1))
            state <= DONE;
        end
        DONE: begin
          digit_hundreds <= bcd_q[11:8];
          digit_tens     <= bcd_q[7:4];
          digit_ones     <= bcd_q[3:0];
          digits_valid   <= 1'b1;
          digits_update  <= !digits_valid ||
                            (bcd_q != {digit_hundreds, digit_tens, digit_ones});
          // A first conversion of 0 has no prior nonzero value, so no time-up.
          time_up        <= digits_valid && (last_converted != '0) && (conv_q == '0);
          last_converted <= conv_q;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign blink_active = digits_valid && (last_converted != '0) &&
                        (last_converted <= CONV_BITS'(LOW_TIME_THRESHOLD));

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      blink_cnt     <= '0;
      blink_visible <= 1'b1;
    end else if (blink_active) begin
      if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_cnt     <= '0;
        blink_visible <= ~blink_visible;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt     <= '0;
      blink_visible <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_digit_decoder.sv
// tb/tb_timer_digit_decoder.sv - scoreboard bench for timer_digit_decoder
module tb_timer_digit_decoder;

  logic               vga_clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] seconds_count = 32'sd0;
  logic [3:0]         digit_hundreds, digit_tens, digit_ones;
  logic               digits_valid, digits_update, time_up, blink_visible;

  timer_digit_decoder #(
    .VALUE_WIDTH(32), .CONV_BITS(10), .LOW_TIME_THRESHOLD(10), .BLINK_TICKS(4)
  ) dut (
    .vga_clock(vga_clock), .reset(reset), .seconds_count(seconds_count),
    .digit_hundreds(digit_hundreds), .digit_tens(digit_tens), .digit_ones(digit_ones),
    .digits_valid(digits_valid), .digits_update(digits_update),
    .time_up(time_up), .blink_visible(blink_visible)
  );

  always #5 vga_clock = ~vga_clock;

  typedef struct {
    int value;
    bit tu;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   disp = 0;
  bit   have_disp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int clamp_val(input int v);
    if (v < 0) return 0;
    if (v > 999) return 999;
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // The displayed value only changes (and pulses) when the clamped input differs.
  task automatic model_set(input int v);
    int   c;
    exp_t e;
    c = clamp_val(v);
    if (!have_disp || c != disp) begin
      e.value = c;
      e.tu    = have_disp && disp != 0 && c == 0;
      exp_q.push_back(e);
    end
    disp      = c;
    have_disp = 1'b1;
  endtask

  task automatic apply(input int v, input int hold);
    @(posedge vga_clock);
    #1;
    seconds_count = v;
    model_set(v);
    repeat (hold) @(posedge vga_clock);
  endtask

  // Monitor: pops the scoreboard on each update pulse and tracks expected blink phase.
  int mon_disp = 0;
  bit mon_valid = 1'b0;
  bit act_d = 1'b0;
  int k = 0;

  always @(negedge vga_clock) begin
    exp_t e;
    bit   act;
    if (reset) begin
      mon_valid = 1'b0;
      mon_disp  = 0;
      act_d     = 1'b0;
      k         = 0;
    end else begin
      if (act_d) k++;
      else k = 0;
      check("blink_visible", 32'(blink_visible), 32'(((k / 4) % 2) == 0));
      if (digits_update) begin
        if (exp_q.size() == 0) begin
          check("spurious_update", 32'(digits_update), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("digits", 32'({digit_hundreds, digit_tens, digit_ones}), 32'(to_bcd(e.value)));
          check("time_up", 32'(time_up), 32'(e.tu));
          check("digits_valid", 32'(digits_valid), 32'd1);
          mon_disp  = e.value;
          mon_valid = 1'b1;
        end
      end else if (time_up) begin
        check("time_up_without_update", 32'(time_up), 32'd0);
      end
      act   = mon_valid && mon_disp > 0 && mon_disp <= 10;
      act_d = act;
    end
  end

  initial begin
    int v;
    int r;
    int waited;

    // Reset with 60 held: first conversion lands exactly 13 edges after release.
    reset         = 1'b1;
    seconds_count = 32'sd60;
    model_set(60);
    repeat (3) @(posedge vga_clock);
    #1;
    check("reset_digits", 32'({digit_hundreds, digit_tens, digit_ones}), 32'd0);
    check("reset_valid", 32'(digits_valid), 32'd0);
    check("reset_blink", 32'(blink_visible), 32'd1);
    check("reset_update", 32'(digits_update), 32'd0);
    reset = 1'b0;
    repeat (12) @(posedge vga_clock);
    #1;
    check("first_not_yet_valid", 32'(digits_valid), 32'd0);
    @(posedge vga_clock);
    #1;
    check("first_valid", 32'(digits_valid), 32'd1);
    check("first_digits", 32'({digit_hundreds, digit_tens, digit_ones}), 32'h060);
    check("first_update", 32'(digits_update), 32'd1);
    repeat (5) @(posedge vga_clock);

    // 60 -> 59 latency: unchanged after 12 edges, new digits after 13.
    @(posedge vga_clock);
    #1;
    seconds_count = 32'sd59;
    model_set(59);
    @(posedge vga_clock);
    repeat (12) @(posedge vga_clock);
    #1;
    check("hold_old_digits", 32'({digit_hundreds, digit_tens, digit_ones}), 32'h060);
    @(posedge vga_clock);
    #1;
    check("latency_digits", 32'({digit_hundreds, digit_tens, digit_ones}), 32'h059);
    check("latency_update", 32'(digits_update), 32'd1);
    repeat (5) @(posedge vga_clock);

    // Clamp boundaries and values exercising every add-3 path.
    apply(-5, 20);
    apply(1234, 20);
    apply(999, 20);
    apply(1000, 20);
    apply(0, 20);
    apply(1, 20);
    apply(-1, 20);
    apply(987, 20);

    // Change while the converter is shifting: 12 is shown, then 11.
    apply(13, 20);
    apply(12, 5);
    apply(11, 25);

    // Low-time blink and time-up.
    apply(10, 30);
    apply(1, 30);
    apply(0, 20);
    apply(11, 20);
    apply(10, 25);
    apply(0, 20);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: v = -int'($urandom_range(1, 50));
        1: v = int'($urandom_range(1000, 5000));
        2: v = int'($urandom_range(0, 12));
        default: v = int'($urandom_range(0, 999));
      endcase
      apply(v, int'($urandom_range(16, 30)));
    end

    // Reset mid-conversion: asynchronous return to reset values, then a forced reconversion.
    @(posedge vga_clock);
    #1;
    seconds_count = 32'sd321;
    model_set(321);
    repeat (5) @(posedge vga_clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_digits", 32'({digit_hundreds, digit_tens, digit_ones}), 32'd0);
    check("async_reset_valid", 32'(digits_valid), 32'd0);
    check("async_reset_blink", 32'(blink_visible), 32'd1);
    check("async_reset_time_up", 32'(time_up), 32'd0);
    exp_q.delete();
    have_disp = 1'b0;
    model_set(321);
    repeat (2) @(posedge vga_clock);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge vga_clock);
    apply(321, 20);

    waited = 0;
    while (exp_q.size() != 0 && waited < 60) begin
      @(posedge vga_clock);
      waited++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
